// File: rtl/flappy_pkg.sv
// Shared screen geometry and colour constants for the Flappy Bird scene.
package flappy_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] GROUND_Y  = 10'd440;

    localparam rgb_t SKY    = 12'h4CF;
    localparam rgb_t BIRD   = 12'hFF0;
    localparam rgb_t PIPE   = 12'h0B0;
    localparam rgb_t GROUND = 12'h852;
    localparam rgb_t BLACK  = 12'h000;

endpackage

// File: rtl/rect_hit.sv
// Half-open range test: hit when lo <= value < lo + size.
module rect_hit #(
    parameter int W = 10
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] size,
    output logic         hit
);

    // Upper bound carries one extra bit so lo + size never wraps.
    logic [W:0] hi;

    assign hi  = {1'b0, lo} + {1'b0, size};
    assign hit = (value >= lo) && ({1'b0, value} < hi);

endmodule

// File: rtl/pixel_renderer.sv
// Two-stage scene renderer: hit flags, then priority colour mux.
module pixel_renderer
    import flappy_pkg::*;
#(
    parameter int BIRD_X    = 100,
    parameter int BIRD_SIZE = 16,
    parameter int PIPE_W    = 52,
    parameter int GAP_H     = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_idx,
    input  logic [9:0] v_idx,
    input  logic       valid,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] bird_y,
    input  logic [9:0] pipe_x,
    input  logic [9:0] gap_y,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam logic [9:0] BX = 10'(BIRD_X);
    localparam logic [9:0] BS = 10'(BIRD_SIZE);
    localparam logic [9:0] PW = 10'(PIPE_W);
    localparam logic [9:0] GH = 10'(GAP_H);

    logic [9:0] bird_y_l;
    logic [9:0] pipe_x_l;
    logic [9:0] gap_y_l;
    logic       match;
    logic       match_d;
    logic       fs_set;

    assign match  = (v_idx == V_VISIBLE) && (h_idx == 10'd0);
    assign fs_set = match && !match_d;

    // Shadows swap only at the blanking edge so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_d     <= 1'b0;
            frame_start <= 1'b0;
            bird_y_l    <= 10'd240;
            pipe_x_l    <= 10'd640;
            gap_y_l     <= 10'd180;
        end else begin
            match_d     <= match;
            frame_start <= fs_set;
            if (fs_set) begin
                bird_y_l <= bird_y;
                pipe_x_l <= pipe_x;
                gap_y_l  <= gap_y;
            end
        end
    end

    logic bx_hit;
    logic by_hit;
    logic px_hit;
    logic gy_hit;

    rect_hit #(.W(10)) u_bird_x (
        .value(h_idx), .lo(BX), .size(BS), .hit(bx_hit)
    );
    rect_hit #(.W(10)) u_bird_y (
        .value(v_idx), .lo(bird_y_l), .size(BS), .hit(by_hit)
    );
    rect_hit #(.W(10)) u_pipe_x (
        .value(h_idx), .lo(pipe_x_l), .size(PW), .hit(px_hit)
    );
    rect_hit #(.W(10)) u_gap_y (
        .value(v_idx), .lo(gap_y_l), .size(GH), .hit(gy_hit)
    );

    logic s1_valid;
    logic s1_hsync;
    logic s1_vsync;
    logic s1_bird;
    logic s1_pipe;
    logic s1_ground;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
            s1_bird   <= 1'b0;
            s1_pipe   <= 1'b0;
            s1_ground <= 1'b0;
        end else begin
            s1_valid  <= valid;
            s1_hsync  <= hsync_in;
            s1_vsync  <= vsync_in;
            s1_bird   <= bx_hit && by_hit;
            s1_pipe   <= (pipe_x_l < H_VISIBLE) && px_hit && !gy_hit;
            s1_ground <= v_idx >= GROUND_Y;
        end
    end

    rgb_t pix_next;
    rgb_t pix;

    always_comb begin
        pix_next = BLACK;
        if (!s1_valid) begin
            pix_next = BLACK;
        end else if (s1_bird) begin
            pix_next = BIRD;
        end else if (s1_pipe) begin
            pix_next = PIPE;
        end else if (s1_ground) begin
            pix_next = GROUND;
        end else begin
            pix_next = SKY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix   <= BLACK;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pix   <= pix_next;
            hsync <= s1_hsync;
            vsync <= s1_vsync;
        end
    end

    assign red   = pix.r;
    assign green = pix.g;
    assign blue  = pix.b;

endmodule
